// File: rtl/bitboard_square_serializer_pkg.sv
// -----------------------------------------------------------------------------
// bitboard_square_serializer_pkg
// Shared chess-board types and constants for the bitboard serializer.
//   SQUARES    : bitboard width, bit i = square i (file = i[2:0], rank = i[5:3])
//   SQ_IDX_W   : square index width
//   CNT_W      : popcount width (0..64 needs one extra bit)
//   FILE_A/H   : edge-file masks, handy for attack-mask producers and benches
//   lsb_clear  : removes the lowest set bit of a bitboard
// -----------------------------------------------------------------------------
package bitboard_square_serializer_pkg;

    localparam int SQUARES  = 64;
    localparam int SQ_IDX_W = 6;
    localparam int CNT_W    = SQ_IDX_W + 1;

    typedef logic [SQUARES-1:0]  bitboard_t;
    typedef logic [SQ_IDX_W-1:0] square_t;
    typedef logic [CNT_W-1:0]    sq_count_t;

    localparam bitboard_t FILE_A = 64'h0101_0101_0101_0101;
    localparam bitboard_t FILE_H = 64'h8080_8080_8080_8080;

    // x & (x-1) drops the lowest set bit; zero stays zero.
    function automatic bitboard_t lsb_clear(input bitboard_t bb);
        return bb & (bb - 64'd1);
    endfunction

endpackage

// File: rtl/bitboard_square_serializer_if.sv
// -----------------------------------------------------------------------------
// bitboard_square_serializer_if
// Bundles the bitboard input handshake, the square output handshake and the
// end-of-board done/count report.
//   slave  : the serializer (accepts boards, produces squares)
//   master : the environment (supplies boards, consumes squares)
// -----------------------------------------------------------------------------
interface bitboard_square_serializer_if;
    import bitboard_square_serializer_pkg::*;

    logic      bb_valid;
    bitboard_t bb_data;
    logic      bb_ready;
    logic      sq_valid;
    square_t   sq_index;
    logic      sq_last;
    logic      sq_ready;
    logic      done;
    sq_count_t count;

    modport slave (
        input  bb_valid, bb_data, sq_ready,
        output bb_ready, sq_valid, sq_index, sq_last, done, count
    );

    modport master (
        output bb_valid, bb_data, sq_ready,
        input  bb_ready, sq_valid, sq_index, sq_last, done, count
    );

endinterface

// File: rtl/bitboard_square_serializer_lsb.sv
// -----------------------------------------------------------------------------
// bitboard_lsb
// Combinational priority encoder: index of the lowest set bit of a bitboard.
//   i_mask  : bitboard to encode
//   o_index : index of lowest set bit (0 when i_mask is empty)
//   o_any   : i_mask has at least one bit set
// -----------------------------------------------------------------------------
module bitboard_lsb
    import bitboard_square_serializer_pkg::*;
(
    input  bitboard_t i_mask,
    output square_t   o_index,
    output logic      o_any
);

    // Scan from the top down so the lowest set bit is the last one to win.
    always_comb begin
        o_index = '0;
        o_any   = 1'b0;
        for (int i = SQUARES - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_index = square_t'(i);
                o_any   = 1'b1;
            end else begin
                o_index = o_index;
                o_any   = o_any;
            end
        end
    end

endmodule

// File: rtl/bitboard_square_serializer.sv
// -----------------------------------------------------------------------------
// bitboard_square_serializer
// Takes one 64-bit attack/move bitboard per handshake and emits the index of
// every set bit, lowest first, one square per accepted beat, then a one-cycle
// done pulse carrying the number of squares emitted.
//   i_clk    : clock, all state on rising edge
//   i_rst    : synchronous active-high reset; outputs forced low while high
//   i_flush  : abandon the current board and return to IDLE (no done pulse)
//   io_bus   : bb_valid/bb_data/bb_ready  board input handshake
//              sq_valid/sq_index/sq_last/sq_ready  square output handshake
//              done/count  end-of-board pulse and popcount
// -----------------------------------------------------------------------------
module bitboard_square_serializer
    import bitboard_square_serializer_pkg::*;
(
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_flush,
    bitboard_square_serializer_if.slave    io_bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0] r_state;
    bitboard_t  r_mask;
    sq_count_t  r_count;

    square_t    w_lsb_index;
    logic       w_lsb_any;
    bitboard_t  w_mask_rest;
    logic       w_last;
    logic       w_bb_ready;
    logic       w_accept;
    logic       w_sq_valid;
    logic       w_beat;

    bitboard_lsb u_lsb (
        .i_mask  (r_mask),
        .o_index (w_lsb_index),
        .o_any   (w_lsb_any)
    );

    // The remaining mask after this beat; empty means the current square is the last.
    assign w_mask_rest = lsb_clear(r_mask);
    assign w_last      = (w_mask_rest == 64'd0);

    // Outputs are gated by reset so they read low for the whole reset window,
    // even on the first reset edge when the state register is still stale.
    assign w_bb_ready = (r_state == ST_IDLE) && !i_rst && !i_flush;
    assign w_accept   = io_bus.bb_valid && w_bb_ready;
    assign w_sq_valid = (r_state == ST_SCAN) && w_lsb_any && !i_rst;
    assign w_beat     = w_sq_valid && io_bus.sq_ready;

    assign io_bus.bb_ready = w_bb_ready;
    assign io_bus.sq_valid = w_sq_valid;
    assign io_bus.sq_index = w_sq_valid ? w_lsb_index : 6'd0;
    assign io_bus.sq_last  = w_sq_valid && w_last;
    assign io_bus.done     = (r_state == ST_DONE) && !i_rst;
    assign io_bus.count    = r_count;

    // State, mask and count update; flush outranks every handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_mask  <= 64'd0;
            r_count <= 7'd0;
        end else if (i_flush) begin
            r_state <= ST_IDLE;
            r_mask  <= 64'd0;
            r_count <= 7'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_mask  <= io_bus.bb_data;
                        r_count <= 7'd0;
                        r_state <= (io_bus.bb_data != 64'd0) ? ST_SCAN : ST_DONE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (w_beat) begin
                        r_mask  <= w_mask_rest;
                        r_count <= r_count + 7'd1;
                        r_state <= w_last ? ST_DONE : ST_SCAN;
                    end else begin
                        r_state <= ST_SCAN;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_mask  <= 64'd0;
                    r_count <= 7'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitboard_square_serializer.sv
// -----------------------------------------------------------------------------
// tb_bitboard_square_serializer
// Table of boards driven through the serializer; expected squares and counts are
// queued at drive time and popped by a negedge monitor. Hand sequences cover
// flush mid-board and reset mid-board.
// -----------------------------------------------------------------------------
module tb_bitboard_square_serializer;
    import bitboard_square_serializer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    bit   stall_en = 1'b0;
    int   cyc = 0;

    bitboard_square_serializer_if bus();

    bitboard_square_serializer dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (flush),
        .io_bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [5:0] idx; logic last; } sq_exp_t;
    typedef struct { logic [63:0] data; bit stall; int exp_cnt; int final_idx; } vec_t;

    sq_exp_t sq_q[$];
    int      done_q[$];
    int      total = 0;
    int      bad   = 0;
    int      done_cnt = 0;
    int      done_cyc = 0;
    int      last_beat_cyc = 0;
    int      final_idx_seen = 0;
    bit      hold_vld = 1'b0;
    logic [5:0] hold_idx;
    logic       hold_last;
    vec_t    tbl[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Random stalls on the square side when enabled.
    initial begin
        bus.sq_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.sq_ready = stall_en ? ($urandom_range(0, 99) >= 35) : 1'b1;
        end
    end

    // Scoreboard monitor, sampling midway between rising edges.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.sq_valid && !flush) begin
                if (hold_vld) begin
                    chk("stall_idx_stable", 64'(bus.sq_index), 64'(hold_idx));
                    chk("stall_last_stable", 64'(bus.sq_last), 64'(hold_last));
                end
                if (bus.sq_ready) begin
                    hold_vld = 1'b0;
                    if (sq_q.size() == 0) begin
                        chk("unexpected_square", 64'(bus.sq_index), 64'd64);
                    end else begin
                        sq_exp_t e;
                        e = sq_q.pop_front();
                        chk("sq_index", 64'(bus.sq_index), 64'(e.idx));
                        chk("sq_last", 64'(bus.sq_last), 64'(e.last));
                        if (e.last) begin
                            last_beat_cyc  = cyc;
                            final_idx_seen = int'(bus.sq_index);
                        end
                    end
                end else begin
                    hold_vld  = 1'b1;
                    hold_idx  = bus.sq_index;
                    hold_last = bus.sq_last;
                end
            end else begin
                hold_vld = 1'b0;
            end
            if (bus.done) begin
                done_cyc = cyc;
                done_cnt++;
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 64'(bus.count), 64'd127);
                end else begin
                    chk("done_count", 64'(bus.count), 64'(done_q.pop_front()));
                end
            end
        end else begin
            hold_vld = 1'b0;
        end
    end

    // Queue the bench's own expectation for a board: every set bit, ascending.
    task automatic push_expect(input logic [63:0] data, input int max_beats);
        int hi;
        int n;
        sq_exp_t e;
        hi = -1;
        for (int i = 0; i < 64; i++) if (data[i]) hi = i;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (data[i] && n < max_beats) begin
                e.idx  = 6'(i);
                e.last = (i == hi);
                sq_q.push_back(e);
                n++;
            end
        end
    endtask

    task automatic run_board(input vec_t v);
        int t;
        int d0;
        int acc_cyc;
        stall_en = v.stall;
        t = 0;
        @(posedge clk);
        #1;
        while (!bus.bb_ready && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!bus.bb_ready) begin
            chk("bb_ready_timeout", 64'd0, 64'd1);
            return;
        end
        push_expect(v.data, 64);
        done_q.push_back(v.exp_cnt);
        d0 = done_cnt;
        bus.bb_valid = 1'b1;
        bus.bb_data  = v.data;
        @(posedge clk);
        #1;
        acc_cyc      = cyc;
        bus.bb_valid = 1'b0;
        bus.bb_data  = ~v.data;
        t = 0;
        while (done_cnt == d0 && t < 600) begin
            @(posedge clk);
            #1;
            t++;
        end
        stall_en = 1'b0;
        if (done_cnt == d0) begin
            chk("done_timeout", 64'd0, 64'd1);
            return;
        end
        chk("bb_ready_after_done", 64'(bus.bb_ready), 64'd1);
        chk("count_held_idle", 64'(bus.count), 64'(v.exp_cnt));
        if (!v.stall) chk("done_latency", 64'(done_cyc - acc_cyc), 64'(v.exp_cnt));
        if (v.exp_cnt > 0) begin
            chk("done_after_last", 64'(done_cyc - last_beat_cyc), 64'd1);
            chk("final_idx", 64'(final_idx_seen), 64'(v.final_idx));
        end
    endtask

    task automatic chk_outputs_low(input string tag);
        chk({tag, "_bb_ready"}, 64'(bus.bb_ready), 64'd0);
        chk({tag, "_sq_valid"}, 64'(bus.sq_valid), 64'd0);
        chk({tag, "_sq_index"}, 64'(bus.sq_index), 64'd0);
        chk({tag, "_sq_last"},  64'(bus.sq_last),  64'd0);
        chk({tag, "_done"},     64'(bus.done),     64'd0);
    endtask

    initial begin
        int d0;
        rst          = 1'b1;
        flush        = 1'b0;
        bus.bb_valid = 1'b0;
        bus.bb_data  = 64'd0;

        tbl[0] = '{64'h0000_0000_0000_0010, 1'b0, 1,  4};
        tbl[1] = '{64'h0000_0000_0000_7070, 1'b0, 6,  14};
        tbl[2] = '{64'h0000_0000_0000_0000, 1'b0, 0,  0};
        tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64, 63};
        tbl[4] = '{64'h8000_0000_0000_0001, 1'b0, 2,  63};
        tbl[5] = '{FILE_A,                  1'b1, 8,  56};
        tbl[6] = '{FILE_H,                  1'b0, 8,  63};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_low("reset");
        rst = 1'b0;
        #1;
        chk("reset_release_bb_ready", 64'(bus.bb_ready), 64'd1);
        chk("reset_count", 64'(bus.count), 64'd0);

        for (int i = 0; i < 7; i++) run_board(tbl[i]);

        // Flush after the third beat of a board; the fourth square is dropped.
        push_expect(64'h8000_0000_0000_00FF, 3);
        d0 = done_cnt;
        bus.bb_valid = 1'b1;
        bus.bb_data  = 64'h8000_0000_0000_00FF;
        @(posedge clk);
        #1;
        bus.bb_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_idle_bb_ready", 64'(bus.bb_ready), 64'd0);
        chk("flush_sq_valid", 64'(bus.sq_valid), 64'd0);
        chk("flush_count", 64'(bus.count), 64'd0);
        flush = 1'b0;
        #1;
        chk("flush_release_bb_ready", 64'(bus.bb_ready), 64'd1);
        chk("flush_beats_consumed", 64'(sq_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("flush_no_done", 64'(done_cnt), 64'(d0));
        run_board('{64'h0000_0000_0000_0002, 1'b0, 1, 1});

        // Reset in the middle of a full board.
        push_expect(64'hFFFF_FFFF_FFFF_FFFF, 2);
        d0 = done_cnt;
        bus.bb_valid = 1'b1;
        bus.bb_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk);
        #1;
        bus.bb_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_outputs_low("midreset_a");
        @(posedge clk);
        #1;
        chk_outputs_low("midreset_b");
        rst = 1'b0;
        #1;
        chk("midreset_release_bb_ready", 64'(bus.bb_ready), 64'd1);
        chk("midreset_count", 64'(bus.count), 64'd0);
        @(posedge clk);
        #1;
        chk("midreset_not_resumed", 64'(bus.sq_valid), 64'd0);
        chk("midreset_no_done", 64'(done_cnt), 64'(d0));
        chk("midreset_beats_consumed", 64'(sq_q.size()), 64'd0);
        run_board('{64'h0000_0000_0000_0010, 1'b0, 1, 4});

        repeat (3) @(posedge clk);
        chk("sq_queue_empty", 64'(sq_q.size()), 64'd0);
        chk("done_queue_empty", 64'(done_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
